// File: rtl/sound_seq_pkg.sv
// Shared command encoding for the sound-bus sequencer and its command FIFO.
package sound_seq_pkg;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    WAIT  = 2'd3
  } seq_op_t;

  typedef struct packed {
    seq_op_t     op;
    logic [15:0] addr;
    logic [7:0]  data;
  } seq_cmd_t;

  localparam logic [15:0] SEQ_IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head and registered count.
module seq_cmd_fifo
  import sound_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  seq_cmd_t wr_cmd,
  input  logic     pop,
  output seq_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  seq_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            do_push, do_pop;

  // A full FIFO refuses the push even when the same clk pops a slot free.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pokey_bus_sequencer.sv
// Replays queued WRITE/READ/WAIT commands onto the sound block's CPU-side bus
// with 3 MHz access pacing and 6 kHz WAIT pacing.
module pokey_bus_sequencer
  import sound_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WAIT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_3MHz_en,
  input  logic        clk_6KHz_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic [15:0] addr_to_bram,
  output logic [7:0]  data_to_bram,
  output logic        should_read,
  input  logic [7:0]  data_from_bram,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_GAP,
    ST_WAIT
  } state_t;

  state_t              state, state_nxt;
  seq_cmd_t            wr_cmd, head, cmd_q;
  logic                full, empty, pop;
  logic [WAIT_W-1:0]   wait_cnt;

  assign wr_cmd    = '{op: seq_op_t'(cmd_op), addr: cmd_addr, data: cmd_data};
  assign cmd_ready = ~full;
  assign busy      = ~empty | (state != ST_IDLE);

  seq_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (cmd_valid),
    .wr_cmd (wr_cmd),
    .pop    (pop),
    .head   (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          unique case (head.op)
            WRITE, READ: state_nxt = ST_SETUP;
            WAIT:        if (head.data[WAIT_W-1:0] != '0) state_nxt = ST_WAIT;
            default:     state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_SETUP:  if (clk_3MHz_en) state_nxt = ST_ACCESS;
      ST_ACCESS: if (clk_3MHz_en) state_nxt = ST_GAP;
      ST_GAP:    if (clk_3MHz_en) state_nxt = ST_IDLE;
      ST_WAIT:   if (clk_6KHz_en && wait_cnt == WAIT_W'(1)) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus is cleared on the same edge that ends ACCESS, so the address is
  // valid for exactly one 3 MHz period and reads as idle through GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q        <= '0;
      wait_cnt     <= '0;
      addr_to_bram <= SEQ_IDLE_ADDR;
      data_to_bram <= 8'h00;
      should_read  <= 1'b0;
      rd_data      <= 8'h00;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            cmd_q    <= head;
            wait_cnt <= head.data[WAIT_W-1:0];
          end
        end
        ST_SETUP: begin
          if (clk_3MHz_en) begin
            addr_to_bram <= cmd_q.addr;
            data_to_bram <= cmd_q.data;
            should_read  <= (cmd_q.op == WRITE);
          end
        end
        ST_ACCESS: begin
          if (clk_3MHz_en) begin
            should_read  <= 1'b0;
            addr_to_bram <= SEQ_IDLE_ADDR;
            data_to_bram <= 8'h00;
            if (cmd_q.op == READ) begin
              rd_data  <= data_from_bram;
              rd_valid <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          addr_to_bram <= SEQ_IDLE_ADDR;
          data_to_bram <= 8'h00;
        end
        ST_WAIT: begin
          if (clk_6KHz_en) wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pokey_bus_sequencer.sv
// Directed bench: 3 MHz strobe every 8 clk, 6 kHz strobe every 20 clk.
module tb_pokey_bus_sequencer;

  localparam logic [1:0] OP_NOP = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2, OP_WT = 2'd3;

  logic        clk, rst, clk_3MHz_en, clk_6KHz_en;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr, addr_to_bram;
  logic [7:0]  cmd_data, data_to_bram, data_from_bram, rd_data;
  logic        should_read, rd_valid, busy;

  int tests_run = 0;
  int tests_failed = 0;

  pokey_bus_sequencer #(.DEPTH(8), .WAIT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_3MHz_en    (clk_3MHz_en),
    .clk_6KHz_en    (clk_6KHz_en),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_data       (cmd_data),
    .addr_to_bram   (addr_to_bram),
    .data_to_bram   (data_to_bram),
    .should_read    (should_read),
    .data_from_bram (data_from_bram),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int c3, c6;
    c3 = 0; c6 = 0;
    clk_3MHz_en = 1'b0;
    clk_6KHz_en = 1'b0;
    forever begin
      @(negedge clk);
      c3 = c3 + 1;
      c6 = c6 + 1;
      clk_3MHz_en = (c3 % 8 == 0);
      clk_6KHz_en = (c6 % 20 == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d,
                      output logic acc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    #1 acc = cmd_ready;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy still %b after %0d clk, expected 0", name, busy, bound);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", 32'(addr_to_bram), 32'h0);
    check("reset_data", 32'(data_to_bram), 32'h0);
    check("reset_should_read", 32'(should_read), 32'h0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write();
    logic acc;
    int sr_cyc, bad, after_addr;
    logic prev;
    sr_cyc = 0; bad = 0; after_addr = -1; prev = 1'b0;
    push(OP_WR, 16'h1820, 8'hA0, acc);
    check("write_accept", 32'(acc), 32'h1);
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
      if (should_read) begin
        sr_cyc++;
        if (addr_to_bram !== 16'h1820 || data_to_bram !== 8'hA0) bad++;
      end else if (prev && after_addr < 0) begin
        after_addr = int'(addr_to_bram);
      end
      prev = should_read;
    end
    check("write_strobe_len", 32'(sr_cyc), 32'd8);
    check("write_bus_stable", 32'(bad), 32'd0);
    check("write_addr_after", 32'(after_addr), 32'h0);
    wait_idle("write_idle", 50);
  endtask

  task automatic test_read();
    logic acc;
    int sr_cyc, rv_cyc, addr_cyc;
    logic [7:0] got;
    sr_cyc = 0; rv_cyc = 0; addr_cyc = 0; got = 8'h00;
    data_from_bram = 8'h5A;
    push(OP_RD, 16'h1828, 8'h00, acc);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (should_read) sr_cyc++;
      if (addr_to_bram == 16'h1828) addr_cyc++;
      if (rd_valid) begin rv_cyc++; got = rd_data; end
    end
    check("read_no_strobe", 32'(sr_cyc), 32'd0);
    check("read_addr_len", 32'(addr_cyc), 32'd8);
    check("read_valid_pulses", 32'(rv_cyc), 32'd1);
    check("read_data", 32'(got), 32'h5A);
    wait_idle("read_idle", 50);
  endtask

  task automatic test_wait();
    logic acc;
    int ticks, lat;
    ticks = 0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (clk_6KHz_en) break;
    end
    push(OP_WT, 16'h0000, 8'd3, acc);
    push(OP_WR, 16'h1840, 8'h20, acc);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (clk_6KHz_en) ticks++;
      if (should_read) break;
    end
    check("wait3_ticks_before_strobe", 32'(ticks), 32'd3);
    check("wait3_write_addr", 32'(addr_to_bram), 32'h1840);
    wait_idle("wait3_idle", 100);
    push(OP_WT, 16'h0000, 8'd0, acc);
    push(OP_WR, 16'h1840, 8'h20, acc);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (should_read) break;
    end
    tests_run++;
    if (lat > 9 || !should_read) begin
      tests_failed++;
      $display("FAIL wait0_latency: strobe after %0d clk, expected <= 9", lat);
    end
    wait_idle("wait0_idle", 100);
  endtask

  task automatic test_full();
    logic acc, all_acc, acc9;
    logic [15:0] seen [16];
    int n;
    logic prev;
    n = 0; prev = 1'b0; all_acc = 1'b1;
    push(OP_WT, 16'h0000, 8'd255, acc);
    for (int i = 0; i < 8; i++) begin
      push(OP_WR, 16'h1800 + 16'(i), 8'(i), acc);
      all_acc &= acc;
    end
    push(OP_WR, 16'h1900, 8'hFF, acc9);
    check("full_eight_accepted", 32'(all_acc), 32'h1);
    check("full_ninth_ready", 32'(acc9), 32'h0);
    for (int i = 0; i < 8000 && busy; i++) begin
      @(posedge clk); #1;
      if (should_read && !prev) begin
        if (n < 16) seen[n] = addr_to_bram;
        n++;
      end
      prev = should_read;
    end
    check("full_exec_count", 32'(n), 32'd8);
    for (int i = 0; i < 8 && i < n; i++)
      check($sformatf("full_order_%0d", i), 32'(seen[i]), 32'h1800 + i);
    wait_idle("full_idle", 10);
  endtask

  task automatic test_back_to_back();
    logic acc, prev, busy_gap;
    int rises, falls, gap_len, gap_bad;
    prev = 1'b0; rises = 0; falls = 0; gap_len = 0; gap_bad = 0; busy_gap = 1'b0;
    push(OP_WR, 16'h1820, 8'h11, acc);
    push(OP_WR, 16'h1840, 8'h22, acc);
    for (int i = 0; i < 300 && busy; i++) begin
      @(posedge clk); #1;
      if (should_read && !prev) rises++;
      if (!should_read && prev) begin
        falls++;
        if (falls == 2) busy_gap = busy;
      end
      if (falls == 1 && rises == 1 && !should_read) begin
        gap_len++;
        if (addr_to_bram != 16'h0000) gap_bad++;
      end
      prev = should_read;
    end
    check("b2b_strobes", 32'(rises), 32'd2);
    tests_run++;
    if (gap_len < 8) begin
      tests_failed++;
      $display("FAIL b2b_gap_len: gap %0d clk, expected >= 8", gap_len);
    end
    check("b2b_gap_addr_idle", 32'(gap_bad), 32'd0);
    check("b2b_busy_in_gap", 32'(busy_gap), 32'h1);
    wait_idle("b2b_idle", 10);
  endtask

  task automatic test_reset_mid();
    logic acc;
    int sr_cyc, addr_cyc, busy_cyc;
    sr_cyc = 0; addr_cyc = 0; busy_cyc = 0;
    push(OP_WR, 16'h1820, 8'h55, acc);
    push(OP_WR, 16'h1111, 8'h01, acc);
    push(OP_WR, 16'h2222, 8'h02, acc);
    push(OP_WR, 16'h3333, 8'h03, acc);
    for (int i = 0; i < 100 && !should_read; i++) begin
      @(posedge clk); #1;
    end
    check("rstmid_in_access", 32'(should_read), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_should_read", 32'(should_read), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rstmid_addr", 32'(addr_to_bram), 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (should_read) sr_cyc++;
      if (addr_to_bram != 16'h0000) addr_cyc++;
      if (busy) busy_cyc++;
    end
    check("rstmid_no_strobe", 32'(sr_cyc), 32'd0);
    check("rstmid_no_addr", 32'(addr_cyc), 32'd0);
    check("rstmid_no_busy", 32'(busy_cyc), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP;
    cmd_addr = 16'h0; cmd_data = 8'h0; data_from_bram = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_wait();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
